// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: bundles the requester side and UART-transmitter side of the
// UART transmit arbiter.
//   req_valid   [3:0]  per-requester byte-pending flags (bit i = requester i)
//   req_data    [31:0] requester i byte on bits [8i+7:8i]
//   req_ready   [3:0]  one-cycle accept pulse per requester
//   din         [7:0]  byte to the UART transmitter
//   wr_en              one-cycle write strobe to the UART transmitter
//   tx_busy            UART transmitter busy flag
//   grant_id    [1:0]  index of the last granted requester
//   arb_busy           arbiter not idle
//   err_timeout        sticky: tx_busy failed to rise after a write
// Modports: master = environment (requesters + UART), slave = arbiter.
interface uart_tx_arb_if;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*BYTE_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]       din;
  logic                    wr_en;
  logic                    tx_busy;
  logic [IDX_W-1:0]        grant_id;
  logic                    arb_busy;
  logic                    err_timeout;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, din, wr_en, grant_id, arb_busy, err_timeout
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, din, wr_en, grant_id, arb_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that feeds bytes from four requesters into
// a single UART transmitter, one byte per tx_busy rise/fall cycle.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - uart_tx_arb_if.slave (requester handshake + UART write port)
// Parameter:
//   BUSY_TIMEOUT - cycles to wait for tx_busy to rise after a write (1-255)
// Optional build macro:
//   UART_TX_ARB_PRIO0_EN - requester 0 gets fixed priority; requesters 1-3
//                          rotate among themselves.
module uart_tx_arb #(
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.slave  bus
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Winner search: scan offsets from high to low so the lowest offset from
  // ptr (the highest round-robin priority) is the final assignment.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = ptr;
    cand     = ptr;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
`ifdef UART_TX_ARB_PRIO0_EN
      if ((cand != '0) && bus.req_valid[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
`else
      if (bus.req_valid[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
`endif
    end
`ifdef UART_TX_ARB_PRIO0_EN
    // Requester 0 overrides the rotation among 1-3.
    if (bus.req_valid[0]) begin
      pick_any = 1'b1;
      pick_idx = '0;
    end
`endif
  end

  // State machine with registered outputs; wr_en/req_ready default low so
  // they can only ever pulse for the single cycle after a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bus.din         <= '0;
      bus.wr_en       <= 1'b0;
      bus.req_ready   <= '0;
      bus.grant_id    <= '0;
      bus.arb_busy    <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.wr_en     <= 1'b0;
      bus.req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (!bus.tx_busy && pick_any) begin
            bus.din       <= bus.req_data[{pick_idx, 3'b000} +: BYTE_W];
            bus.wr_en     <= 1'b1;
            bus.req_ready <= N_REQ'(1) << pick_idx;
            bus.grant_id  <= pick_idx;
            bus.arb_busy  <= 1'b1;
            cnt           <= '0;
            state         <= WAIT_RISE;
`ifdef UART_TX_ARB_PRIO0_EN
            // ptr only follows the rotating group 1-3; 0 wraps to 1 in search.
            if (pick_idx != '0) begin
              ptr <= pick_idx + IDX_W'(1);
            end
`else
            ptr <= pick_idx + IDX_W'(1);
`endif
          end
        end
        WAIT_RISE: begin
          if (bus.tx_busy) begin
            cnt   <= '0;
            state <= WAIT_FALL;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never acknowledged the byte: flag it and move on.
            cnt             <= '0;
            bus.err_timeout <= 1'b1;
            bus.arb_busy    <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_FALL: begin
          if (!bus.tx_busy) begin
            bus.arb_busy <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          bus.arb_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb. Expected grants are
// pushed when requests are driven and popped when wr_en is observed.
module tb_uart_tx_arb;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if bus();

  uart_tx_arb #(.BUSY_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   grant_cnt   = 0;
  int   cyc         = 0;
  int   wr_cyc      = 0;
  int   err_cyc     = -1;
  logic [1:0] m_ptr = 2'd0;
  bit   auto_drop   = 1'b1;
  bit   uart_en     = 1'b0;
  bit   force_busy  = 1'b0;
  int   uart_len    = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] c;
`ifdef UART_TX_ARB_PRIO0_EN
    if (v[0]) return 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      c = p + 2'(k);
`ifdef UART_TX_ARB_PRIO0_EN
      if (c != 2'd0 && v[c]) return c;
`else
      if (v[c]) return c;
`endif
    end
    return 2'd0;
  endfunction

  task automatic exp_grant();
    logic [1:0] g;
    exp_t e;
    g    = model_pick(bus.req_valid, m_ptr);
    e.id = g;
    e.b  = bus.req_data[{g, 3'b000} +: 8];
    q.push_back(e);
`ifdef UART_TX_ARB_PRIO0_EN
    if (g != 2'd0) m_ptr = g + 2'd1;
`else
    m_ptr = g + 2'd1;
`endif
  endtask

  // One cycle step; a requester drops its flag once it sees its accept pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) bus.req_valid = bus.req_valid & ~bus.req_ready;
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int n = 0;
    while (grant_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(grant_cnt), 32'(target));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((bus.arb_busy || bus.tx_busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.arb_busy), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    m_ptr = 2'd0;
  endtask

  // UART transmitter model: busy for uart_len cycles after each write.
  initial begin
    int rem;
    rem = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en) begin
        if (bus.wr_en) rem = uart_len;
        if (rem > 0) begin
          bus.tx_busy = 1'b1;
          rem--;
        end else begin
          bus.tx_busy = 1'b0;
        end
      end else begin
        rem = 0;
        bus.tx_busy = force_busy;
      end
    end
  end

  // Output monitor: pops the scoreboard on every write strobe.
  initial begin
    logic prev_wr;
    exp_t e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_wr) begin
        check("wr_pulse", 32'(bus.wr_en), 32'd0);
        check("rdy_pulse", 32'(bus.req_ready), 32'd0);
      end
      if (bus.wr_en) begin
        wr_cyc = cyc;
        grant_cnt++;
        if (q.size() == 0) begin
          check("unexp_grant", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("din", 32'(bus.din), 32'(e.b));
          check("grant_id", 32'(bus.grant_id), 32'(e.id));
          check("req_ready", 32'(bus.req_ready), 32'(4'b0001 << e.id));
        end
      end else if (bus.req_ready != 4'd0) begin
        check("rdy_stray", 32'(bus.req_ready), 32'd0);
      end
      if (bus.err_timeout && err_cyc < 0) err_cyc = cyc;
      prev_wr = bus.wr_en;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0;
    bus.req_valid = 4'd0;
    bus.req_data  = 32'd0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_din", 32'(bus.din), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    rst   = 1'b0;
    m_ptr = 2'd0;

    // Single request from requester 2.
    uart_en = 1'b1; uart_len = 3; auto_drop = 1'b1;
    bus.req_data  = 32'h0041_0000;
    bus.req_valid = 4'b0100;
    exp_grant();
    check("single_pre_wr", 32'(bus.wr_en), 32'd0);
    tick();
    check("single_wr", 32'(bus.wr_en), 32'd1);
    check("single_din", 32'(bus.din), 32'h41);
    check("single_rdy", 32'(bus.req_ready), 32'b0100);
    check("single_gid", 32'(bus.grant_id), 32'd2);
    check("single_busy", 32'(bus.arb_busy), 32'd1);
    wait_idle(50, "single_idle");

    // Fairness: all four held, 10-cycle transmitter.
    auto_drop = 1'b0; uart_len = 10;
    pulse_reset();
    bus.req_data  = 32'hD3C2_B1A0;
    bus.req_valid = 4'hF;
    repeat (5) exp_grant();
    g0 = grant_cnt;
    wait_grants(g0 + 5, 400, "fair_grants");
    bus.req_valid = 4'd0;
    wait_idle(50, "fair_idle");
    auto_drop = 1'b1;

    // Timeout: transmitter never goes busy.
    uart_en = 1'b0; force_busy = 1'b0;
    bus.req_data  = 32'h0000_005A;
    bus.req_valid = 4'b0001;
    exp_grant();
    g0 = grant_cnt;
    wait_grants(g0 + 1, 20, "to_grant");
    for (int n = 0; n < 40 && !bus.err_timeout; n++) tick();
    tick();
    check("to_flag", 32'(bus.err_timeout), 32'd1);
    check("to_latency", 32'(err_cyc - wr_cyc), 32'(TO));
    check("to_idle", 32'(bus.arb_busy), 32'd0);
    uart_en = 1'b1; uart_len = 3;
    bus.req_data  = 32'h0000_6B00;
    bus.req_valid = 4'b0010;
    exp_grant();
    g0 = grant_cnt;
    wait_grants(g0 + 1, 20, "to_next_grant");
    wait_idle(50, "to_next_idle");
    check("to_sticky", 32'(bus.err_timeout), 32'd1);

    // Reset in WAIT_FALL.
    uart_len = 10;
    bus.req_data  = 32'h0000_7C00;
    bus.req_valid = 4'b0010;
    exp_grant();
    g0 = grant_cnt;
    wait_grants(g0 + 1, 20, "mb_grant");
    repeat (4) tick();
    check("mb_in_flight", 32'(bus.arb_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mb_din", 32'(bus.din), 32'd0);
    check("mb_wr_en", 32'(bus.wr_en), 32'd0);
    check("mb_rdy", 32'(bus.req_ready), 32'd0);
    check("mb_gid", 32'(bus.grant_id), 32'd0);
    check("mb_busy", 32'(bus.arb_busy), 32'd0);
    check("mb_err", 32'(bus.err_timeout), 32'd0);
    tick();
    rst   = 1'b0;
    m_ptr = 2'd0;
    uart_len = 3;
    wait_idle(50, "mb_settle");
    // ptr back at 0: requester 0 ahead of 3.
    bus.req_data  = 32'h9300_0090;
    bus.req_valid = 4'b1001;
    exp_grant();
    g0 = grant_cnt;
    wait_grants(g0 + 1, 20, "mb_ptr_grant0");
    exp_grant();
    wait_grants(g0 + 2, 40, "mb_ptr_grant1");
    wait_idle(50, "mb_ptr_idle");

    // Reset coinciding with a would-be grant.
    bus.req_data  = 32'h00A5_0000;
    bus.req_valid = 4'b0100;
    rst = 1'b1;
    tick();
    check("rs_no_wr", 32'(bus.wr_en), 32'd0);
    check("rs_no_rdy", 32'(bus.req_ready), 32'd0);
    rst   = 1'b0;
    m_ptr = 2'd0;
    exp_grant();
    tick();
    check("rs_grant", 32'(bus.wr_en), 32'd1);
    wait_idle(50, "rs_idle");

    // Busy blocking in IDLE.
    uart_en = 1'b0; force_busy = 1'b1;
    tick();
    tick();
    bus.req_data  = 32'h0000_00C3;
    bus.req_valid = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("bb_hold", 32'(bus.wr_en), 32'd0);
    end
    exp_grant();
    force_busy = 1'b0;
    check("bb_pre", 32'(bus.wr_en), 32'd0);
    tick();
    check("bb_grant", 32'(bus.wr_en), 32'd1);
    force_busy = 1'b1;
    repeat (3) tick();
    force_busy = 1'b0;
    wait_idle(50, "bb_idle");

`ifdef UART_TX_ARB_PRIO0_EN
    // Fixed priority for requester 0, rotation among 1-3.
    uart_en = 1'b1; uart_len = 3; auto_drop = 1'b0;
    pulse_reset();
    bus.req_data  = 32'h3300_1100;
    bus.req_valid = 4'b1011;
    repeat (3) exp_grant();
    g0 = grant_cnt;
    wait_grants(g0 + 3, 100, "prio_zero");
    bus.req_valid = 4'b1010;
    repeat (3) exp_grant();
    wait_grants(g0 + 6, 100, "prio_rr");
    bus.req_valid = 4'd0;
    wait_idle(50, "prio_idle");
    auto_drop = 1'b1;
`endif

    repeat (3) tick();
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
